// File: rtl/qspis_wb_arb.sv
// rtl/qspis_wb_arb.sv - two-requester round-robin arbiter and sequencer for one Wishbone master port
// Optional bus timeout: define QSPIS_WB_TIMEOUT_EN to abort a WB cycle that sees no ack/err.
module qspis_wb_arb #(
  parameter int         TMO_W   = 10,
  parameter logic [3:0] ADR_PAD = 4'b0
) (
  input  logic        mclk,
  input  logic        rst,
  // requester 0: QSPI slave register interface
  input  logic        r0_wr,
  input  logic        r0_rd,
  input  logic [23:0] r0_addr,
  input  logic [3:0]  r0_be,
  input  logic [31:0] r0_wdata,
  output logic [31:0] r0_rdata,
  output logic        r0_ack,
  output logic        r0_err,
  // requester 1: UART/debug master register interface
  input  logic        r1_wr,
  input  logic        r1_rd,
  input  logic [23:0] r1_addr,
  input  logic [3:0]  r1_be,
  input  logic [31:0] r1_wdata,
  output logic [31:0] r1_rdata,
  output logic        r1_ack,
  output logic        r1_err,
  // Wishbone master port
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;

  // index of the requester that owns the current cycle
  logic gnt;
  // last granted index; rr_vld stays low until the first grant so req0 wins the first tie
  logic rr;
  logic rr_vld;

  logic req0_v;
  logic req1_v;
  logic pick;

  logic        bus_done;
  logic        done_err;
  logic [31:0] done_data;
  logic        load_rdata;

`ifdef QSPIS_WB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo_w;
  assign unused_tmo_w = (TMO_W != 0);
`endif

  assign req0_v = r0_wr | r0_rd;
  assign req1_v = r1_wr | r1_rd;

  // choose the requester to grant: sole requester, or the one not served last on a tie
  always_comb begin
    pick = 1'b0;
    if (req0_v && req1_v) begin
      pick = rr_vld ? ~rr : 1'b0;
    end else if (req1_v) begin
      pick = 1'b1;
    end
  end

  // decide whether the running bus cycle ends this edge and with what result
  always_comb begin
    bus_done   = 1'b0;
    done_err   = 1'b0;
    done_data  = wbm_dat_i;
    load_rdata = ~wbm_we_o;
    if (wbm_ack_i || wbm_err_i) begin
      // err wins when both arrive together
      bus_done = 1'b1;
      done_err = wbm_err_i;
    end
`ifdef QSPIS_WB_TIMEOUT_EN
    else if (tmo_cnt == TMO_LAST) begin
      // counter reaches all-ones on this edge: abort with an error and all-ones data
      bus_done   = 1'b1;
      done_err   = 1'b1;
      done_data  = 32'hFFFF_FFFF;
      load_rdata = 1'b1;
    end
`endif
  end

  // sequencer: IDLE grants, BUS runs one WB cycle, HOLD gives the requester time to drop its request
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      rr        <= 1'b0;
      rr_vld    <= 1'b0;
      r0_rdata  <= 32'h0;
      r0_ack    <= 1'b0;
      r0_err    <= 1'b0;
      r1_rdata  <= 32'h0;
      r1_ack    <= 1'b0;
      r1_err    <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_adr_o <= 32'h0;
      wbm_we_o  <= 1'b0;
      wbm_dat_o <= 32'h0;
      wbm_sel_o <= 4'h0;
`ifdef QSPIS_WB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // ack and err are single-cycle pulses
      r0_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_ack <= 1'b0;
      r1_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_v || req1_v) begin
            gnt       <= pick;
            wbm_adr_o <= {ADR_PAD, 4'h0, (pick ? r1_addr : r0_addr)};
            wbm_we_o  <= pick ? r1_wr : r0_wr;
            wbm_dat_o <= pick ? r1_wdata : r0_wdata;
            wbm_sel_o <= pick ? r1_be : r0_be;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= S_BUS;
`ifdef QSPIS_WB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        S_BUS: begin
          if (bus_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= S_HOLD;
            if (gnt) begin
              r1_ack <= 1'b1;
              r1_err <= done_err;
              if (load_rdata) begin
                r1_rdata <= done_data;
              end
            end else begin
              r0_ack <= 1'b1;
              r0_err <= done_err;
              if (load_rdata) begin
                r0_rdata <= done_data;
              end
            end
          end
`ifdef QSPIS_WB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          rr     <= gnt;
          rr_vld <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspis_wb_arb.sv
// tb/tb_qspis_wb_arb.sv - directed self-checking bench for qspis_wb_arb
module tb_qspis_wb_arb;

  logic        mclk;
  logic        rst;
  logic        r0_wr, r0_rd;
  logic [23:0] r0_addr;
  logic [3:0]  r0_be;
  logic [31:0] r0_wdata;
  logic [31:0] r0_rdata;
  logic        r0_ack, r0_err;
  logic        r1_wr, r1_rd;
  logic [23:0] r1_addr;
  logic [3:0]  r1_be;
  logic [31:0] r1_wdata;
  logic [31:0] r1_rdata;
  logic        r1_ack, r1_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int vectors;
  int miscompares;

  qspis_wb_arb #(
    .TMO_W   (4),
    .ADR_PAD (4'b0)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .r0_wr     (r0_wr),
    .r0_rd     (r0_rd),
    .r0_addr   (r0_addr),
    .r0_be     (r0_be),
    .r0_wdata  (r0_wdata),
    .r0_rdata  (r0_rdata),
    .r0_ack    (r0_ack),
    .r0_err    (r0_err),
    .r1_wr     (r1_wr),
    .r1_rd     (r1_rd),
    .r1_addr   (r1_addr),
    .r1_be     (r1_be),
    .r1_wdata  (r1_wdata),
    .r1_rdata  (r1_rdata),
    .r1_ack    (r1_ack),
    .r1_err    (r1_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge mclk);
  endtask

  // slave completes the current cycle: drive ack/err for one edge, return at the following negedge
  task automatic wb_reply(input logic ack, input logic err, input logic [31:0] data);
    wbm_ack_i = ack;
    wbm_err_i = err;
    wbm_dat_i = data;
    step();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    r0_wr = 0; r0_rd = 0; r0_addr = 0; r0_be = 0; r0_wdata = 0;
    r1_wr = 0; r1_rd = 0; r1_addr = 0; r1_be = 0; r1_wdata = 0;
    wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    step();
    step();

    // reset state
    check("rst_cyc",    {31'h0, wbm_cyc_o}, 32'h0);
    check("rst_stb",    {31'h0, wbm_stb_o}, 32'h0);
    check("rst_adr",    wbm_adr_o, 32'h0);
    check("rst_r0_ack", {31'h0, r0_ack}, 32'h0);
    check("rst_r0_rd",  r0_rdata, 32'h0);
    check("rst_r1_rd",  r1_rdata, 32'h0);
    rst = 1'b0;
    step();

    // single read from requester 0
    r0_rd = 1'b1; r0_addr = 24'h00_1234; r0_be = 4'hF;
    step();
    check("rd_cyc",  {31'h0, wbm_cyc_o}, 32'h1);
    check("rd_stb",  {31'h0, wbm_stb_o}, 32'h1);
    check("rd_adr",  wbm_adr_o, 32'h0000_1234);
    check("rd_we",   {31'h0, wbm_we_o}, 32'h0);
    step();
    step();
    check("rd_wait_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    check("rd_wait_ack", {31'h0, r0_ack}, 32'h0);
    wb_reply(1'b1, 1'b0, 32'hCAFE_0001);
    check("rd_ack",    {31'h0, r0_ack}, 32'h1);
    check("rd_rdata",  r0_rdata, 32'hCAFE_0001);
    check("rd_err",    {31'h0, r0_err}, 32'h0);
    check("rd_r1_ack", {31'h0, r1_ack}, 32'h0);
    check("rd_cyc_off", {31'h0, wbm_cyc_o}, 32'h0);
    r0_rd = 1'b0;
    step();
    check("rd_ack_pulse", {31'h0, r0_ack}, 32'h0);
    check("rd_hold_cyc",  {31'h0, wbm_cyc_o}, 32'h0);
    step();

    // single write from requester 1; inputs changed mid-cycle must not leak through
    r1_wr = 1'b1; r1_addr = 24'hAB_CDEF; r1_be = 4'b0011; r1_wdata = 32'h5A5A_A5A5;
    step();
    check("wr_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    check("wr_we",  {31'h0, wbm_we_o}, 32'h1);
    check("wr_sel", {28'h0, wbm_sel_o}, 32'h3);
    check("wr_dat", wbm_dat_o, 32'h5A5A_A5A5);
    check("wr_adr", wbm_adr_o, 32'h00AB_CDEF);
    r1_wdata = 32'h0; r1_addr = 24'h0; r1_be = 4'hF;
    step();
    check("wr_dat_stable", wbm_dat_o, 32'h5A5A_A5A5);
    check("wr_sel_stable", {28'h0, wbm_sel_o}, 32'h3);
    wb_reply(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("wr_ack",       {31'h0, r1_ack}, 32'h1);
    check("wr_r1_rdata",  r1_rdata, 32'h0);
    check("wr_r0_ack",    {31'h0, r0_ack}, 32'h0);
    check("wr_r0_rdata",  r0_rdata, 32'hCAFE_0001);
    r1_wr = 1'b0;
    step();
    step();

    // contention from reset: both reads held, grants must alternate 0,1,0,1
    rst = 1'b1;
    r0_rd = 1'b1; r0_addr = 24'h00_0010;
    r1_rd = 1'b1; r1_addr = 24'h00_0020;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("ct%0d_cyc", k), {31'h0, wbm_cyc_o}, 32'h1);
      check($sformatf("ct%0d_adr", k), wbm_adr_o, (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020);
      wb_reply(1'b1, 1'b0, 32'h100 + k);
      if (k == 3) begin
        r0_rd = 1'b0;
        r1_rd = 1'b0;
      end
      check($sformatf("ct%0d_r0_ack", k), {31'h0, r0_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("ct%0d_r1_ack", k), {31'h0, r1_ack}, (k % 2 == 0) ? 32'h0 : 32'h1);
      check($sformatf("ct%0d_rdata", k), (k % 2 == 0) ? r0_rdata : r1_rdata, 32'h100 + k);
      check($sformatf("ct%0d_cyc_off", k), {31'h0, wbm_cyc_o}, 32'h0);
      step();
      check($sformatf("ct%0d_idle", k), {31'h0, wbm_cyc_o}, 32'h0);
    end
    step();
    check("ct_quiet", {31'h0, wbm_cyc_o}, 32'h0);

    // error with ack in the same cycle: err wins
    r0_rd = 1'b1; r0_addr = 24'h00_0300;
    step();
    check("er_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    wb_reply(1'b1, 1'b1, 32'h0000_1111);
    check("er_ack",   {31'h0, r0_ack}, 32'h1);
    check("er_err",   {31'h0, r0_err}, 32'h1);
    check("er_rdata", r0_rdata, 32'h0000_1111);
    r0_rd = 1'b0;
    step();
    check("er_err_clr", {31'h0, r0_err}, 32'h0);
    step();

    // silent slave
    r0_rd = 1'b1; r0_addr = 24'h00_0400;
    step();
    check("to_cyc", {31'h0, wbm_cyc_o}, 32'h1);
`ifdef QSPIS_WB_TIMEOUT_EN
    repeat (14) step();
    check("to_cyc_15", {31'h0, wbm_cyc_o}, 32'h1);
    step();
    check("to_cyc_off", {31'h0, wbm_cyc_o}, 32'h0);
    check("to_ack",     {31'h0, r0_ack}, 32'h1);
    check("to_err",     {31'h0, r0_err}, 32'h1);
    check("to_rdata",   r0_rdata, 32'hFFFF_FFFF);
`else
    repeat (100) step();
    check("to_cyc_100", {31'h0, wbm_cyc_o}, 32'h1);
    check("to_no_ack",  {31'h0, r0_ack}, 32'h0);
    wb_reply(1'b1, 1'b0, 32'h0000_4444);
    check("to_ack",   {31'h0, r0_ack}, 32'h1);
    check("to_rdata", r0_rdata, 32'h0000_4444);
`endif
    r0_rd = 1'b0;
    step();
    step();

    // asynchronous reset in the middle of a cycle, then a clean reissued write
    r1_wr = 1'b1; r1_addr = 24'h00_0444; r1_be = 4'b1100; r1_wdata = 32'h0000_0077;
    step();
    check("ar_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("ar_cyc_off", {31'h0, wbm_cyc_o}, 32'h0);
    check("ar_stb_off", {31'h0, wbm_stb_o}, 32'h0);
    check("ar_ack",     {31'h0, r1_ack}, 32'h0);
    r1_wr = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("ar_idle", {31'h0, wbm_cyc_o}, 32'h0);
    r1_wr = 1'b1;
    step();
    check("ar2_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    check("ar2_we",  {31'h0, wbm_we_o}, 32'h1);
    check("ar2_adr", wbm_adr_o, 32'h0000_0444);
    check("ar2_sel", {28'h0, wbm_sel_o}, 32'hC);
    check("ar2_dat", wbm_dat_o, 32'h0000_0077);
    wb_reply(1'b1, 1'b0, 32'h0);
    check("ar2_ack",   {31'h0, r1_ack}, 32'h1);
    check("ar2_err",   {31'h0, r1_err}, 32'h0);
    check("ar2_r0ack", {31'h0, r0_ack}, 32'h0);
    r1_wr = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qspis_wb_arb.md
Name: qspis_wb_arb

Overview:
- Registered two-requester arbiter and sequencer in front of a single Wishbone master port.
- Requester 0 is the QSPI slave register interface; requester 1 is the UART/debug master register interface.
- Each requester uses the level-style reg_wr/reg_rd/reg_ack protocol. The block grants one requester at a time, runs exactly one WB cycle, and returns registered read data plus an error flag.

Parameters:
- TMO_W, 10, width of the bus-timeout counter; timeout fires after 2^TMO_W-1 cycles without ack/err.
- ADR_PAD, 4'b0, constant upper nibble prepended to the 24-bit request address.

Ports:
- mclk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- r0_wr  input  1  req0 write request (level, held until r0_ack)
- r0_rd  input  1  req0 read request (level, held until r0_ack)
- r0_addr  input  24  req0 address
- r0_be  input  4  req0 byte enable
- r0_wdata  input  32  req0 write data
- r0_rdata  output  32  req0 read data, valid with r0_ack
- r0_ack  output  1  req0 completion pulse, 1 cycle
- r0_err  output  1  req0 error flag, valid with r0_ack
- r1_wr, r1_rd, r1_addr, r1_be, r1_wdata, r1_rdata, r1_ack, r1_err  same as r0_* for requester 1
- wbm_cyc_o  output  1  WB cycle
- wbm_stb_o  output  1  WB strobe
- wbm_adr_o  output  32  {ADR_PAD, granted addr}
- wbm_we_o  output  1  WB write
- wbm_dat_o  output  32  WB write data
- wbm_sel_o  output  4  WB byte select
- wbm_dat_i  input  32  WB read data
- wbm_ack_i  input  1  WB ack
- wbm_err_i  input  1  WB error

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0, so req0 has priority on the first tie; timeout counter 0.
- States:
  - IDLE: sample req_valid = wr|rd per requester.
    - Neither valid: stay in IDLE.
    - One valid: grant it.
    - Both valid: grant the requester that is NOT the last granted (round-robin).
    - On grant: latch addr/be/wdata/we (we = wr; wr has priority if wr and rd are both high), set cyc=stb=1, go to BUS.
  - BUS: cyc/stb/adr/we/dat/sel held stable.
    - On wbm_ack_i or wbm_err_i: drop cyc/stb next edge; register wbm_dat_i into the granted rdata (reads only; writes leave rdata unchanged); pulse the granted ack; err = wbm_err_i; go to HOLD.
    - If ack and err arrive together, err wins (err=1).
  - HOLD: one cycle with no bus activity, letting the requester deassert its request. Update the rr pointer to the granted index, then go to IDLE.
- Latency: request high at edge N → cyc/stb high after edge N+1. WB ack at edge M → reqX_ack high for the cycle after edge M+1, and cyc low in that same cycle. Minimum 3 cycles request-to-ack; next grant no earlier than 2 cycles after ack.
- Non-granted requester's ack/err stay 0. Its rdata holds its last value.
- Requests that drop before grant are ignored; no partial cycles are issued.
- Request inputs changing during BUS have no effect; the latched values are used.
- Async reset mid-BUS: cyc/stb drop immediately, no ack is returned, state goes to IDLE. The requester must reissue.

Optional Feature:
- Macro QSPIS_WB_TIMEOUT_EN.
- Defined: TMO_W counter clears on entering BUS and increments each BUS cycle. When it reaches all-ones with no ack/err, the block:
  - drops cyc/stb,
  - pulses the granted ack with err=1 and rdata=32'hFFFF_FFFF,
  - goes to HOLD.
  - An ack arriving in the same cycle as expiry wins and is a normal completion.
- Not defined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- Single read: r0_rd=1, r0_addr=24'h00_1234; slave acks after 2 cycles with 32'hCAFE_0001 → wbm_adr_o=32'h0000_1234, we=0; r0_ack 1 cycle, r0_rdata=32'hCAFE_0001, r0_err=0; r1_ack stays 0.
- Single write: r1_wr=1, be=4'b0011, wdata=32'h5A5A_A5A5 → wbm_we_o=1, sel=4'b0011, dat_o=32'h5A5A_A5A5; r1_ack after slave ack; r1_rdata unchanged.
- Contention: r0_rd and r1_rd both held continuously from reset, responding to each ack → grant order 0,1,0,1; exactly one cyc per grant; at least one idle cycle between cycles.
- Error: slave returns wbm_err_i=1 (with ack=1 same cycle) → r0_ack=1, r0_err=1.
- Timeout (QSPIS_WB_TIMEOUT_EN, TMO_W=4): slave never acks → cyc drops after 15 BUS cycles, r0_ack=1, r0_err=1, r0_rdata=32'hFFFF_FFFF. Without the macro, cyc is still high after 100 cycles.
- Reset mid-cycle: assert rst while cyc=1 → cyc/stb/ack go 0 asynchronously; after release, a new r1_wr completes normally.
